control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Bus bundle between control_unit and its datapath/memories.
// The master modport is the control unit; the slave modport is the datapath side.
interface control_unit_if;
  logic [6:0]  pc_addr;
  logic [15:0] instr_data;
  logic [7:0]  d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [3:0]  rf_wr_addr;
  logic        rf_write;
  logic [3:0]  rf_rd_addr_a;
  logic [3:0]  rf_rd_addr_b;
  logic [1:0]  rf_wr_sel;
  logic [7:0]  rf_imm;
  logic [1:0]  alu_sel;
  logic        halted;
  logic [3:0]  state;

  modport master (
    output pc_addr, d_addr, d_rd, d_wr, rf_wr_addr, rf_write,
           rf_rd_addr_a, rf_rd_addr_b, rf_wr_sel, rf_imm, alu_sel,
           halted, state,
    input  instr_data
  );

  modport slave (
    input  pc_addr, d_addr, d_rd, d_wr, rf_wr_addr, rf_write,
           rf_rd_addr_a, rf_rd_addr_b, rf_wr_sel, rf_imm, alu_sel,
           halted, state,
    output instr_data
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM driving a
// register file, ALU and data memory. Define LOAD_CONST_EN to enable LOADC.
module control_unit (
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_LOADC  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_LOADC = 4'h6
  } opcode_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;
  opcode_t     w_op;

  logic [7:0]  w_d_addr;
  logic        w_d_rd;
  logic        w_d_wr;
  logic [3:0]  w_rf_wr_addr;
  logic        w_rf_write;
  logic [3:0]  w_rf_rd_addr_a;
  logic [3:0]  w_rf_rd_addr_b;
  logic [1:0]  w_rf_wr_sel;
  logic [7:0]  w_rf_imm;
  logic [1:0]  w_alu_sel;
  logic        w_halted;

  assign w_op = opcode_t'(r_ir[15:12]);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_ir <= bus.instr_data;
        r_pc <= r_pc + 7'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_STORE: w_next = S_STORE;
          OP_LOAD:  w_next = S_LOAD_A;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_HALT:  w_next = S_HALT;
`ifdef LOAD_CONST_EN
          OP_LOADC: w_next = S_LOADC;
`endif
          default:  w_next = S_NOOP;
        endcase
      end
      S_LOAD_A: w_next = S_LOAD_B;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_d_addr       = '0;
    w_d_rd         = 1'b0;
    w_d_wr         = 1'b0;
    w_rf_wr_addr   = '0;
    w_rf_write     = 1'b0;
    w_rf_rd_addr_a = '0;
    w_rf_rd_addr_b = '0;
    w_rf_wr_sel    = 2'b00;
    w_rf_imm       = '0;
    w_alu_sel      = 2'b00;
    w_halted       = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_d_rd   = 1'b1;
        w_d_addr = r_ir[11:4];
      end
      S_LOAD_B: begin
        w_rf_write   = 1'b1;
        w_rf_wr_sel  = 2'b01;
        w_rf_wr_addr = r_ir[3:0];
        w_d_addr     = r_ir[11:4];
      end
      S_STORE: begin
        w_d_wr         = 1'b1;
        w_d_addr       = r_ir[11:4];
        w_rf_rd_addr_a = r_ir[3:0];
      end
      S_ADD, S_SUB: begin
        w_rf_write     = 1'b1;
        w_rf_wr_sel    = 2'b00;
        w_alu_sel      = (r_state == S_ADD) ? 2'b01 : 2'b10;
        w_rf_rd_addr_a = r_ir[11:8];
        w_rf_rd_addr_b = r_ir[7:4];
        w_rf_wr_addr   = r_ir[3:0];
      end
      S_HALT: w_halted = 1'b1;
`ifdef LOAD_CONST_EN
      S_LOADC: begin
        w_rf_write   = 1'b1;
        w_rf_wr_sel  = 2'b10;
        w_rf_imm     = r_ir[11:4];
        w_rf_wr_addr = r_ir[3:0];
      end
`endif
      default: ;
    endcase
    // Reset is synchronous, so the FSM may still sit in a writing state
    // during the reset cycle; suppress strobes so nothing gets committed.
    if (reset) begin
      w_d_rd     = 1'b0;
      w_d_wr     = 1'b0;
      w_rf_write = 1'b0;
    end
  end

  assign bus.pc_addr      = r_pc;
  assign bus.d_addr       = w_d_addr;
  assign bus.d_rd         = w_d_rd;
  assign bus.d_wr         = w_d_wr;
  assign bus.rf_wr_addr   = w_rf_wr_addr;
  assign bus.rf_write     = w_rf_write;
  assign bus.rf_rd_addr_a = w_rf_rd_addr_a;
  assign bus.rf_rd_addr_b = w_rf_rd_addr_b;
  assign bus.rf_wr_sel    = w_rf_wr_sel;
  assign bus.rf_imm       = w_rf_imm;
  assign bus.alu_sel      = w_alu_sel;
  assign bus.halted       = w_halted;
  assign bus.state        = r_state;

endmodule
